// File: rtl/pdc_pkg.sv
// Shared types and reset defaults for the programmable pattern-detection controller.
package pdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pdc_state_t;

    localparam logic [4:0] RESET_PATTERN = 5'b10001;
    localparam logic [3:0] RESET_LEN     = 4'd5;
    localparam int         RESET_TARGET  = 1;

    // A zero length would compare nothing, so it is treated as a single-bit pattern.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len == 4'd0)
            return 4'd1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/pdc_matcher.sv
// Bit history, fill tracking and length-masked compare; match is a Mealy output
// valid in the same cycle as the accepted bit.
module pdc_matcher #(
    parameter int MAX_LEN = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [3:0]         len,
    output logic               match
);

    logic [MAX_LEN-2:0] hist_reg;
    logic [3:0]         fill_reg;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               fill_ok;

    assign window = {hist_reg, bit_in};

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign mask[gi] = (4'(gi) < len);
        end
    endgenerate

    // The incoming bit supplies the last position, so len-1 stored bits suffice.
    assign fill_ok = ({1'b0, fill_reg} + 5'd1) >= {1'b0, len};
    assign match   = accept && fill_ok && (((window ^ pattern) & mask) == '0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (accept) begin
            hist_reg <= window[MAX_LEN-2:0];
            if (fill_reg < len)
                fill_reg <= fill_reg + 4'd1;
        end
    end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Configurable serial pattern-detection controller (IDLE/RUN/DONE).
// Define PDC_TIMEOUT_EN to build the RUN-cycle timeout and timed_out status.
module pattern_det_ctrl
    import pdc_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               bit_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               timed_out
);

    pdc_state_t         state_reg;
    logic [MAX_LEN-1:0] pattern_reg;
    logic [3:0]         len_reg;
    logic [CNT_W-1:0]   target_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W:0]     count_next;
    logic               accept;
    logic               run_clear;
    logic               target_hit;
    logic               timeout_hit;

    assign accept     = bit_valid && (state_reg == RUN);
    assign run_clear  = (state_reg == IDLE) && start;
    assign count_next = {1'b0, count_reg} + (CNT_W+1)'(1);
    assign target_hit = match && (target_reg != '0) && (count_next == {1'b0, target_reg});

    pdc_matcher #(
        .MAX_LEN (MAX_LEN)
    ) u_matcher (
        .clk     (clk),
        .reset   (reset),
        .clear   (run_clear),
        .accept  (accept),
        .bit_in  (bit_in),
        .pattern (pattern_reg),
        .len     (len_reg),
        .match   (match)
    );

`ifdef PDC_TIMEOUT_EN
    logic [TO_W-1:0] timeout_reg;
    logic [TO_W-1:0] timer_reg;
    logic            timed_out_reg;

    assign timeout_hit = (timeout_reg != '0) && ((timer_reg + TO_W'(1)) == timeout_reg);
    assign timed_out   = timed_out_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_reg   <= '0;
            timer_reg     <= '0;
            timed_out_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && cfg_we)
                timeout_reg <= cfg_timeout;
            if (run_clear) begin
                timer_reg     <= '0;
                timed_out_reg <= 1'b0;
            end else if (state_reg == RUN) begin
                timer_reg <= timer_reg + TO_W'(1);
                // A completing match or an abort in the same cycle suppresses the timeout flag.
                if (!abort && !target_hit && timeout_hit)
                    timed_out_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^cfg_timeout;
    assign timeout_hit    = 1'b0;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            pattern_reg <= MAX_LEN'(RESET_PATTERN);
            len_reg     <= RESET_LEN;
            target_reg  <= CNT_W'(RESET_TARGET);
            count_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_we) begin
                        pattern_reg <= cfg_pattern;
                        len_reg     <= clamp_len(cfg_len, 4'(MAX_LEN));
                        target_reg  <= cfg_target;
                    end
                    if (start) begin
                        state_reg <= RUN;
                        count_reg <= '0;
                    end
                end
                RUN: begin
                    if (match && (count_reg != {CNT_W{1'b1}}))
                        count_reg <= count_next[CNT_W-1:0];
                    if (abort)
                        state_reg <= IDLE;
                    else if (target_hit || timeout_hit)
                        state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bit_ready   = (state_reg == RUN);
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign match_count = count_reg;

endmodule
